// File: rtl/wb_pkg.sv
// Shared definitions for the writeback commit slice: exception codes, flag
// bit positions, commit FSM states and CSR number width.
package wb_pkg;

  localparam int CSR_NUM_W = 14;
  localparam int EXV_W_DEF = 5;

  localparam int EXV_ADEF = 0;
  localparam int EXV_INE  = 1;
  localparam int EXV_SYS  = 2;
  localparam int EXV_BRK  = 3;
  localparam int EXV_ALE  = 4;

  localparam logic [5:0] ECODE_NONE = 6'h00;
  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_INE  = 6'h0D;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [8:0] ESUB_NONE  = 9'h000;

  typedef enum logic {
    RUN  = 1'b0,
    KILL = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_exc_prio_enc.sv
// Combinational priority encoder: interrupt, then ADEF, INE, SYS, BRK, ALE.
module wb_exc_prio_enc
  import wb_pkg::*;
#(
  parameter int EXV_W = EXV_W_DEF
) (
  input  logic             i_has_int,
  input  logic [EXV_W-1:0] i_exv,
  output logic             o_ex,
  output logic [5:0]       o_ecode,
  output logic [8:0]       o_esubcode,
  output logic             o_is_addr_err
);

  always_comb begin
    o_ex          = i_has_int | (|i_exv);
    o_ecode       = ECODE_NONE;
    o_esubcode    = ESUB_NONE;
    o_is_addr_err = 1'b0;
    if (i_has_int) begin
      o_ecode = ECODE_INT;
    end else if (i_exv[EXV_ADEF]) begin
      o_ecode       = ECODE_ADEF;
      o_is_addr_err = 1'b1;
    end else if (i_exv[EXV_INE]) begin
      o_ecode = ECODE_INE;
    end else if (i_exv[EXV_SYS]) begin
      o_ecode = ECODE_SYS;
    end else if (i_exv[EXV_BRK]) begin
      o_ecode = ECODE_BRK;
    end else if (i_exv[EXV_ALE]) begin
      o_ecode       = ECODE_ALE;
      o_is_addr_err = 1'b1;
    end else begin
      o_ecode = ECODE_NONE;
    end
  end

endmodule

// File: rtl/wb_exc_commit.sv
// Writeback commit unit: latches MEM results, resolves exceptions/ERTN and
// redirects the front end. Optional trace ports under WB_DEBUG_TRACE_EN.
module wb_exc_commit
  import wb_pkg::*;
#(
  parameter int KILL_CYCLES = 1,
  parameter int EXV_W       = EXV_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ms_valid,
  output logic                 ws_allowin,
  input  logic [31:0]          ms_pc,
  input  logic [31:0]          ms_vaddr,
  input  logic [EXV_W-1:0]     ms_exv,
  input  logic                 ms_is_ertn,
  input  logic                 ms_csr_we,
  input  logic [CSR_NUM_W-1:0] ms_csr_num,
  input  logic [31:0]          ms_csr_wmask,
  input  logic [31:0]          ms_csr_wvalue,
  input  logic                 ms_rf_we,
  input  logic [4:0]           ms_rf_waddr,
  input  logic [31:0]          ms_rf_wdata,
  input  logic                 has_int,
  input  logic [31:0]          csr_eentry,
  input  logic [31:0]          csr_era,
  output logic                 wb_ex,
  output logic [5:0]           wb_ecode,
  output logic [8:0]           wb_esubcode,
  output logic [31:0]          wb_pc,
  output logic [31:0]          wb_vaddr,
  output logic                 ertn_flush,
  output logic                 csr_we,
  output logic [CSR_NUM_W-1:0] csr_num,
  output logic [31:0]          csr_wmask,
  output logic [31:0]          csr_wvalue,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic                 flush_valid,
  output logic [31:0]          flush_target
`ifdef WB_DEBUG_TRACE_EN
  ,
  output logic [31:0]          debug_wb_pc,
  output logic [3:0]           debug_wb_rf_we,
  output logic [4:0]           debug_wb_rf_wnum,
  output logic [31:0]          debug_wb_rf_wdata
`endif
);

  localparam int CNT_W     = (KILL_CYCLES > 1) ? $clog2(KILL_CYCLES) : 1;
  localparam int KILL_INIT = (KILL_CYCLES > 0) ? KILL_CYCLES - 1 : 0;

  logic                 r_valid;
  logic [31:0]          r_pc, r_vaddr, r_csr_wmask, r_csr_wvalue, r_rf_wdata;
  logic [EXV_W-1:0]     r_exv;
  logic                 r_is_ertn, r_csr_we, r_rf_we;
  logic [CSR_NUM_W-1:0] r_csr_num;
  logic [4:0]           r_rf_waddr;
  wb_state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_kill_cnt, w_kill_cnt_nxt;

  logic       w_capture, w_ex, w_is_addr_err, w_ertn;
  logic [5:0] w_ecode;
  logic [8:0] w_esubcode;

  assign w_capture = ms_valid & ws_allowin & ~flush_valid;

  // WB pipeline register; a flush cycle drops whatever MEM is offering
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_capture;
    end
    if (w_capture) begin
      r_pc         <= ms_pc;
      r_vaddr      <= ms_vaddr;
      r_exv        <= ms_exv;
      r_is_ertn    <= ms_is_ertn;
      r_csr_we     <= ms_csr_we;
      r_csr_num    <= ms_csr_num;
      r_csr_wmask  <= ms_csr_wmask;
      r_csr_wvalue <= ms_csr_wvalue;
      r_rf_we      <= ms_rf_we;
      r_rf_waddr   <= ms_rf_waddr;
      r_rf_wdata   <= ms_rf_wdata;
    end
  end

  wb_exc_prio_enc #(.EXV_W(EXV_W)) u_prio (
    .i_has_int     (has_int & r_valid),
    .i_exv         (r_exv & {EXV_W{r_valid}}),
    .o_ex          (w_ex),
    .o_ecode       (w_ecode),
    .o_esubcode    (w_esubcode),
    .o_is_addr_err (w_is_addr_err)
  );

  // Kill-window FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RUN;
      r_kill_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_kill_cnt <= w_kill_cnt_nxt;
    end
  end

  // Kill-window next-state logic
  always_comb begin
    w_state_nxt    = r_state;
    w_kill_cnt_nxt = r_kill_cnt;
    case (r_state)
      RUN: begin
        if (flush_valid && (KILL_CYCLES > 0)) begin
          w_state_nxt    = KILL;
          w_kill_cnt_nxt = CNT_W'(KILL_INIT);
        end else begin
          w_state_nxt = RUN;
        end
      end
      KILL: begin
        if (r_kill_cnt == '0) begin
          w_state_nxt = RUN;
        end else begin
          w_kill_cnt_nxt = r_kill_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt    = RUN;
        w_kill_cnt_nxt = '0;
      end
    endcase
  end

  // Kill-window outputs
  always_comb begin
    ws_allowin = 1'b0;
    case (r_state)
      RUN:     ws_allowin = 1'b1;
      KILL:    ws_allowin = 1'b0;
      default: ws_allowin = 1'b0;
    endcase
  end

  assign w_ertn = r_valid & r_is_ertn & ~w_ex;

  // Commit outputs; everything is held at zero while WB is empty
  always_comb begin
    wb_ex        = w_ex;
    wb_ecode     = w_ecode;
    wb_esubcode  = w_esubcode;
    wb_pc        = r_valid ? r_pc : 32'h0;
    wb_vaddr     = 32'h0;
    ertn_flush   = w_ertn;
    csr_we       = r_valid & r_csr_we & ~w_ex;
    csr_num      = r_valid ? r_csr_num : {CSR_NUM_W{1'b0}};
    csr_wmask    = r_valid ? r_csr_wmask : 32'h0;
    csr_wvalue   = r_valid ? r_csr_wvalue : 32'h0;
    rf_we        = r_valid & r_rf_we & ~w_ex;
    rf_waddr     = r_valid ? r_rf_waddr : 5'h0;
    rf_wdata     = r_valid ? r_rf_wdata : 32'h0;
    flush_valid  = w_ex | w_ertn;
    flush_target = 32'h0;
    if (w_is_addr_err) begin
      wb_vaddr = (w_ecode == ECODE_ADEF) ? r_pc : r_vaddr;
    end else begin
      wb_vaddr = 32'h0;
    end
    if (r_valid) begin
      flush_target = w_ex ? csr_eentry : csr_era;
    end else begin
      flush_target = 32'h0;
    end
  end

`ifdef WB_DEBUG_TRACE_EN
  assign debug_wb_pc       = r_valid ? r_pc : 32'h0;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_exc_commit.sv
// Directed self-checking bench for wb_exc_commit (KILL_CYCLES = 1).
module tb_wb_exc_commit;
  logic        clk = 1'b0;
  logic        reset;
  logic        ms_valid, ms_is_ertn, ms_csr_we, ms_rf_we, has_int;
  logic [31:0] ms_pc, ms_vaddr, ms_csr_wmask, ms_csr_wvalue, ms_rf_wdata;
  logic [4:0]  ms_exv, ms_rf_waddr;
  logic [13:0] ms_csr_num;
  logic [31:0] csr_eentry, csr_era;
  logic        ws_allowin, wb_ex, ertn_flush, csr_we, rf_we, flush_valid;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc, wb_vaddr, csr_wmask, csr_wvalue, rf_wdata, flush_target;
  logic [13:0] csr_num;
  logic [4:0]  rf_waddr;
  int checks = 0;
  int errors = 0;

  wb_exc_commit #(.KILL_CYCLES(1), .EXV_W(5)) dut (
    .clk(clk), .reset(reset), .ms_valid(ms_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_vaddr(ms_vaddr), .ms_exv(ms_exv), .ms_is_ertn(ms_is_ertn),
    .ms_csr_we(ms_csr_we), .ms_csr_num(ms_csr_num), .ms_csr_wmask(ms_csr_wmask),
    .ms_csr_wvalue(ms_csr_wvalue), .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr),
    .ms_rf_wdata(ms_rf_wdata), .has_int(has_int), .csr_eentry(csr_eentry),
    .csr_era(csr_era), .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush), .csr_we(csr_we),
    .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .flush_valid(flush_valid), .flush_target(flush_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ms();
    ms_valid = 1'b0; ms_pc = 32'h0; ms_vaddr = 32'h0; ms_exv = 5'h0;
    ms_is_ertn = 1'b0; ms_csr_we = 1'b0; ms_csr_num = 14'h0;
    ms_csr_wmask = 32'h0; ms_csr_wvalue = 32'h0;
    ms_rf_we = 1'b0; ms_rf_waddr = 5'h0; ms_rf_wdata = 32'h0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ex"}, {31'h0, wb_ex}, 32'h0);
    chk({tag, "_rfwe"}, {31'h0, rf_we}, 32'h0);
    chk({tag, "_csrwe"}, {31'h0, csr_we}, 32'h0);
    chk({tag, "_ertn"}, {31'h0, ertn_flush}, 32'h0);
    chk({tag, "_flush"}, {31'h0, flush_valid}, 32'h0);
    chk({tag, "_tgt"}, flush_target, 32'h0);
    chk({tag, "_pc"}, wb_pc, 32'h0);
  endtask

  initial begin
    reset = 1'b1; has_int = 1'b0;
    csr_eentry = 32'h1c008000; csr_era = 32'h1c000200;
    clear_ms();
    tick(); tick();
    chk_idle("rst");
    chk("rst_allowin", {31'h0, ws_allowin}, 32'h1);
    reset = 1'b0;
    tick();
    chk_idle("post_rst");
    // interrupt with empty WB is ignored
    has_int = 1'b1;
    #1;
    chk("int_idle_ex", {31'h0, wb_ex}, 32'h0);
    chk("int_idle_flush", {31'h0, flush_valid}, 32'h0);
    has_int = 1'b0;

    // plain instruction
    ms_valid = 1'b1; ms_pc = 32'h1c000000; ms_rf_we = 1'b1;
    ms_rf_waddr = 5'd5; ms_rf_wdata = 32'hdeadbeef;
    tick();
    chk("plain_rfwe", {31'h0, rf_we}, 32'h1);
    chk("plain_waddr", {27'h0, rf_waddr}, 32'h5);
    chk("plain_wdata", rf_wdata, 32'hdeadbeef);
    chk("plain_ex", {31'h0, wb_ex}, 32'h0);
    chk("plain_flush", {31'h0, flush_valid}, 32'h0);
    chk("plain_pc", wb_pc, 32'h1c000000);
    clear_ms();
    tick();
    chk("bubble_rfwe", {31'h0, rf_we}, 32'h0);

    // BRK followed by a held-valid instruction that must be killed
    ms_valid = 1'b1; ms_pc = 32'h1c000010; ms_exv = 5'b01000; ms_rf_we = 1'b1;
    ms_rf_waddr = 5'd7; ms_rf_wdata = 32'h11111111;
    tick();
    chk("brk_ex", {31'h0, wb_ex}, 32'h1);
    chk("brk_ecode", {26'h0, wb_ecode}, 32'h0c);
    chk("brk_esub", {23'h0, wb_esubcode}, 32'h0);
    chk("brk_tgt", flush_target, 32'h1c008000);
    chk("brk_flush", {31'h0, flush_valid}, 32'h1);
    chk("brk_rfwe", {31'h0, rf_we}, 32'h0);
    chk("brk_pc", wb_pc, 32'h1c000010);
    ms_pc = 32'h1c000020; ms_exv = 5'h0;
    tick();
    chk("kill1_rfwe", {31'h0, rf_we}, 32'h0);
    chk("kill1_pc", wb_pc, 32'h0);
    chk("kill1_allowin", {31'h0, ws_allowin}, 32'h0);
    tick();
    chk("kill2_rfwe", {31'h0, rf_we}, 32'h0);
    chk("kill2_allowin", {31'h0, ws_allowin}, 32'h1);
    tick();
    chk("resume_rfwe", {31'h0, rf_we}, 32'h1);
    chk("resume_pc", wb_pc, 32'h1c000020);
    clear_ms();
    tick();

    // ALE together with SYS: SYS wins
    ms_valid = 1'b1; ms_pc = 32'h1c000030; ms_vaddr = 32'h1003; ms_exv = 5'b10100;
    tick();
    chk("alesys_ecode", {26'h0, wb_ecode}, 32'h0b);
    chk("alesys_vaddr", wb_vaddr, 32'h0);
    chk("alesys_ex", {31'h0, wb_ex}, 32'h1);
    clear_ms();
    tick(); tick();
    // ALE alone
    ms_valid = 1'b1; ms_pc = 32'h1c000034; ms_vaddr = 32'h1003; ms_exv = 5'b10000;
    tick();
    chk("ale_ecode", {26'h0, wb_ecode}, 32'h09);
    chk("ale_vaddr", wb_vaddr, 32'h1003);
    clear_ms();
    tick(); tick();

    // ERTN with a CSR write, then the same instruction with a pending interrupt
    ms_valid = 1'b1; ms_pc = 32'h1c000040; ms_is_ertn = 1'b1;
    ms_csr_we = 1'b1; ms_csr_num = 14'h6; ms_csr_wmask = 32'hffffffff; ms_csr_wvalue = 32'h12345678;
    tick();
    chk("ertn_flush", {31'h0, ertn_flush}, 32'h1);
    chk("ertn_fv", {31'h0, flush_valid}, 32'h1);
    chk("ertn_tgt", flush_target, 32'h1c000200);
    chk("ertn_ex", {31'h0, wb_ex}, 32'h0);
    chk("ertn_csrwe", {31'h0, csr_we}, 32'h1);
    chk("ertn_csrnum", {18'h0, csr_num}, 32'h6);
    chk("ertn_csrval", csr_wvalue, 32'h12345678);
    has_int = 1'b1;
    #1;
    chk("int_ex", {31'h0, wb_ex}, 32'h1);
    chk("int_ecode", {26'h0, wb_ecode}, 32'h0);
    chk("int_ertn", {31'h0, ertn_flush}, 32'h0);
    chk("int_csrwe", {31'h0, csr_we}, 32'h0);
    chk("int_tgt", flush_target, 32'h1c008000);
    has_int = 1'b0;
    clear_ms();
    tick(); tick();

    // ADEF suppresses the CSR write
    ms_valid = 1'b1; ms_pc = 32'h1c000003; ms_exv = 5'b00001; ms_csr_we = 1'b1;
    ms_csr_num = 14'h5; ms_csr_wvalue = 32'haaaa5555;
    tick();
    chk("adef_ecode", {26'h0, wb_ecode}, 32'h08);
    chk("adef_esub", {23'h0, wb_esubcode}, 32'h0);
    chk("adef_vaddr", wb_vaddr, 32'h1c000003);
    chk("adef_csrwe", {31'h0, csr_we}, 32'h0);
    clear_ms();
    tick();
    chk("adef_kill_allowin", {31'h0, ws_allowin}, 32'h0);

    // reset while in KILL
    reset = 1'b1;
    ms_valid = 1'b1; ms_pc = 32'h1c000050; ms_rf_we = 1'b1;
    tick();
    chk_idle("kill_rst");
    chk("kill_rst_allowin", {31'h0, ws_allowin}, 32'h1);
    reset = 1'b0;
    clear_ms();
    tick();
    chk_idle("after_rst");
    chk("after_rst_allowin", {31'h0, ws_allowin}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_exc_commit.md
Name: wb_exc_commit

Overview:
- Writeback-stage commit unit of the scalar pipeline; sits directly upstream of the CSR file.
- Latches one instruction per cycle from the MEM stage and priority-encodes its exception flags plus the sampled interrupt.
- Drives the CSR exception/ertn/write interface, the register-file write port and the front-end flush redirect.
- Suppresses stale upstream instructions for a programmable window after each flush.

Parameters:
- KILL_CYCLES, 1, cycles after a flush during which ms_valid is ignored (0 = none).
- EXV_W, 5, width of the exception flag vector (ADEF, INE, SYS, BRK, ALE).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ms_valid  in  1  MEM stage holds a valid instruction
- ws_allowin  out  1  WB can accept this cycle
- ms_pc  in  32  instruction PC
- ms_vaddr  in  32  load/store effective address
- ms_exv  in  EXV_W  exception flags, bit0 ADEF, bit1 INE, bit2 SYS, bit3 BRK, bit4 ALE
- ms_is_ertn  in  1  instruction is ERTN
- ms_csr_we / ms_csr_num / ms_csr_wmask / ms_csr_wvalue  in  1/14/32/32  CSR write request
- ms_rf_we / ms_rf_waddr / ms_rf_wdata  in  1/5/32  GPR write
- has_int  in  1  pending-and-enabled interrupt from the CSR file
- csr_eentry / csr_era  in  32/32  redirect targets
- wb_ex / wb_ecode / wb_esubcode / wb_pc / wb_vaddr  out  1/6/9/32/32  exception commit to CSR
- ertn_flush  out  1  ERTN commit
- csr_we / csr_num / csr_wmask / csr_wvalue  out  1/14/32/32  CSR write
- rf_we / rf_waddr / rf_wdata  out  1/5/32  GPR write
- flush_valid / flush_target  out  1/32  front-end redirect

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- State register ws_valid plus latched copies of all ms_* fields. States: RUN and KILL (with a down-counter kill_cnt).
- Reset: ws_valid=0, state=RUN, kill_cnt=0. Every output is 0 while ws_valid=0, including during and immediately after reset.
- ws_allowin=1 in RUN, 0 in KILL.
- Latch rule: at the clock edge, ws_valid <= ms_valid & ws_allowin & ~flush_valid. An incoming instruction in a flush cycle is dropped.
- Latency: outputs for a latched instruction are combinational from the WB registers, in the cycle after capture. The CSR file samples them at the next edge.
- Priority, highest first, with ecode/esubcode:
  - INT (has_int & ws_valid): 0x00/0
  - ADEF: 0x08/0
  - INE: 0x0D/0
  - SYS: 0x0B/0
  - BRK: 0x0C/0
  - ALE: 0x09/0
- ex = ws_valid & (has_int | |exv). wb_ex=ex.
- wb_vaddr = pc on ADEF, vaddr on ALE, 0 otherwise. wb_pc = latched pc.
- When ex=1: rf_we, csr_we and ertn_flush are forced to 0.
- ertn_flush = ws_valid & is_ertn & ~ex.
- flush_valid = ex | ertn_flush. flush_target = ex ? csr_eentry : csr_era.
- On flush_valid: if KILL_CYCLES>0, go to KILL with kill_cnt=KILL_CYCLES-1; otherwise stay in RUN.
- In KILL: ms_valid is ignored. kill_cnt decrements each cycle; return to RUN after the cycle in which kill_cnt==0.
- Simultaneous has_int with ERTN or a CSR write: the interrupt wins and both are suppressed.
- has_int while ws_valid=0: ignored; the interrupt is taken on the next valid instruction.
- A reset asserted in KILL or mid-commit returns the block to the reset state at that edge.

Optional Feature:
- Macro: WB_DEBUG_TRACE_EN.
- When defined, adds outputs debug_wb_pc[32], debug_wb_rf_we[4], debug_wb_rf_wnum[5] and debug_wb_rf_wdata[32]:
  - pc is the latched pc when ws_valid, else 0.
  - rf_we is {4{rf_we}}.
  - Other fields mirror rf_waddr and rf_wdata.
- When undefined, the ports do not exist and no trace logic is generated.

Decomposition:
- Package wb_pkg:
  - ecode/esubcode localparams
  - exv bit indices
  - state enum {RUN, KILL}
  - CSR number width 14
- One natural sub-module: wb_exc_prio_enc, a combinational priority encoder from {has_int, exv} to {ex, ecode, esubcode, is_addr_err}.

Test Plan:
- Plain instruction: pc=0x1c000000, rf_we=1, waddr=5, wdata=0xdeadbeef → next cycle rf_we=1 with those values, wb_ex=0, flush_valid=0.
- BRK at pc=0x1c000010, csr_eentry=0x1c008000:
  - wb_ex=1, ecode=0x0C, flush_target=0x1c008000, rf_we=0.
  - With ms_valid=1 held, no instruction is captured for KILL_CYCLES+1 cycles.
- ALE (vaddr=0x1003) together with SYS flags → ecode=0x0B (SYS wins), wb_vaddr=0. ALE alone → ecode=0x09, wb_vaddr=0x1003.
- ERTN with csr_era=0x1c000200 → ertn_flush=1, flush_target=0x1c000200. Same instruction with has_int=1 → wb_ex=1, ecode=0, ertn_flush=0, target=eentry.
- ADEF at pc=0x1c000003 → ecode=0x08, esubcode=0, wb_vaddr=0x1c000003, csr_we suppressed despite ms_csr_we=1.
- Reset asserted during KILL → ws_valid=0, all outputs 0, ws_allowin=1 on the cycle after reset deasserts.
